// File: rtl/spi_arb_pkg.sv
// Shared types and constants for the SPI transaction arbiter.
// Holds the FSM state encoding, field widths and the lock burst limit.
package spi_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        MODE,
        SETTLE,
        START,
        WAIT_BUSY,
        WAIT_DONE,
        RESP
    } arb_state_t;

    localparam int MODE_W   = 2;
    localparam int SS_W     = 2;
    localparam int BYTE_W   = 8;
    localparam int LOCK_MAX = 16;
    localparam int BURST_W  = $clog2(LOCK_MAX);

    // Round-robin successor of a requester index.
    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/spi_rr_arbiter.sv
// Combinational round-robin picker: first active request at or after ptr.
// Produces a one-hot grant, its index and an any-request flag.
module spi_rr_arbiter
    import spi_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    always_comb begin
        int k;
        gnt = '0;
        idx = '0;
        any = 1'b0;
        k   = 0;
        for (int off = 0; off < NUM_REQ; off++) begin
            k = int'(ptr) + off;
            if (k >= NUM_REQ) k = k - NUM_REQ;
            if (!any && req[k]) begin
                any    = 1'b1;
                gnt[k] = 1'b1;
                idx    = IDX_W'(k);
            end
        end
    end

endmodule

// File: rtl/spi_txn_arbiter.sv
// Shares one SPI master among NUM_REQ requesters, one byte per grant, round-robin.
// Optional watchdog on the master handshake is built with `define SPI_ARB_TIMEOUT_EN.
module spi_txn_arbiter
    import spi_arb_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int SETTLE_CYC  = 2,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                      P_CLK,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        i_REQ,
    input  logic [NUM_REQ-1:0]        i_LOCK,
    input  logic [NUM_REQ*BYTE_W-1:0] i_REQ_DATA,
    input  logic [NUM_REQ*SS_W-1:0]   i_REQ_SS,
    input  logic [NUM_REQ*MODE_W-1:0] i_REQ_MODE,
    output logic [NUM_REQ-1:0]        o_GNT,
    output logic [NUM_REQ-1:0]        o_DONE,
    output logic                      o_ERR,
    output logic [BYTE_W-1:0]         o_RX_BYTE,
    output logic [BYTE_W-1:0]         o_TX_DATA,
    output logic                      o_TX_START,
    output logic [SS_W-1:0]           o_SS,
    output logic [MODE_W-1:0]         o_SPI_MODE,
    output logic                      o_MODE_SET,
    input  logic                      i_SPIC,
    input  logic [BYTE_W-1:0]         i_RX_DATA
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int SET_W = $clog2(SETTLE_CYC + 1);

    arb_state_t         state, state_nxt;
    logic [NUM_REQ-1:0] arb_gnt;
    logic [IDX_W-1:0]   arb_idx, rr_ptr, cur_idx, sel_idx;
    logic               arb_any;
    logic               lock_hold;
    logic [BURST_W-1:0] burst_cnt;
    logic [MODE_W-1:0]  last_mode, sel_mode;
    logic [SET_W-1:0]   settle_cnt;
    logic               take, lock_drop, keep, xfer_done, tmo_hit;

    spi_rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr (
        .req (i_REQ),
        .ptr (rr_ptr),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .any (arb_any)
    );

    // A locked requester skips arbitration entirely; the pointer stays put.
    assign sel_idx   = lock_hold ? cur_idx : arb_idx;
    assign sel_mode  = i_REQ_MODE[sel_idx*MODE_W +: MODE_W];
    assign take      = i_SPIC && (lock_hold ? i_REQ[cur_idx] : arb_any);
    assign lock_drop = lock_hold && !i_REQ[cur_idx];
    assign keep      = i_LOCK[cur_idx] && i_REQ[cur_idx] &&
                       (burst_cnt != BURST_W'(LOCK_MAX - 1));
    assign xfer_done = (state == WAIT_DONE) && i_SPIC;

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TMO_W-1:0] tmo_cnt;
    assign tmo_hit = ((state == WAIT_BUSY) || (state == WAIT_DONE)) && !xfer_done &&
                     (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));
`else
    assign tmo_hit = 1'b0;
    assign o_ERR   = 1'b0;
`endif

    always_ff @(posedge P_CLK or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (take) state_nxt = (sel_mode != last_mode) ? MODE : START;
            MODE:      state_nxt = SETTLE;
            SETTLE:    if (settle_cnt == SET_W'(SETTLE_CYC - 1)) state_nxt = START;
            START:     state_nxt = WAIT_BUSY;
            WAIT_BUSY: if (tmo_hit) state_nxt = RESP;
                       else if (!i_SPIC) state_nxt = WAIT_DONE;
            WAIT_DONE: if (xfer_done || tmo_hit) state_nxt = RESP;
            RESP:      state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge P_CLK or negedge reset_n) begin
        if (!reset_n) begin
            o_GNT      <= '0;
            o_DONE     <= '0;
            o_RX_BYTE  <= '0;
            o_TX_DATA  <= '0;
            o_TX_START <= 1'b0;
            o_SS       <= '0;
            o_SPI_MODE <= '0;
            o_MODE_SET <= 1'b0;
            last_mode  <= '0;
            rr_ptr     <= '0;
            cur_idx    <= '0;
            lock_hold  <= 1'b0;
            burst_cnt  <= '0;
            settle_cnt <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
            o_ERR      <= 1'b0;
            tmo_cnt    <= '0;
`endif
        end else begin
            o_TX_START <= 1'b0;
            o_MODE_SET <= 1'b0;
            o_DONE     <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
            o_ERR      <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (lock_drop) begin
                        o_GNT     <= '0;
                        lock_hold <= 1'b0;
                        burst_cnt <= '0;
                        rr_ptr    <= IDX_W'(rr_next(int'(cur_idx), NUM_REQ));
                    end else if (take) begin
                        if (!lock_hold) begin
                            o_GNT     <= arb_gnt;
                            burst_cnt <= '0;
                        end
                        cur_idx    <= sel_idx;
                        o_TX_DATA  <= i_REQ_DATA[sel_idx*BYTE_W +: BYTE_W];
                        o_SS       <= i_REQ_SS[sel_idx*SS_W +: SS_W];
                        o_SPI_MODE <= sel_mode;
                    end
                end
                MODE: begin
                    o_MODE_SET <= 1'b1;
                    last_mode  <= o_SPI_MODE;
                    settle_cnt <= '0;
                end
                SETTLE: settle_cnt <= settle_cnt + 1'b1;
                START: begin
                    o_TX_START <= 1'b1;
`ifdef SPI_ARB_TIMEOUT_EN
                    tmo_cnt    <= '0;
`endif
                end
                WAIT_BUSY, WAIT_DONE: begin
                    if (xfer_done) begin
                        o_RX_BYTE <= i_RX_DATA;
                        o_DONE    <= o_GNT;
                    end
`ifdef SPI_ARB_TIMEOUT_EN
                    // Master state is unknown after a stall, so force a mode re-issue.
                    else if (tmo_hit) begin
                        o_RX_BYTE <= '0;
                        o_DONE    <= o_GNT;
                        o_ERR     <= 1'b1;
                        last_mode <= 2'b11;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
`endif
                end
                RESP: begin
                    if (keep) begin
                        lock_hold <= 1'b1;
                        burst_cnt <= burst_cnt + 1'b1;
                    end else begin
                        o_GNT     <= '0;
                        lock_hold <= 1'b0;
                        burst_cnt <= '0;
                        rr_ptr    <= IDX_W'(rr_next(int'(cur_idx), NUM_REQ));
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Scoreboard bench for spi_txn_arbiter with a behavioural SPI master (MISO loopback).
// Timeout scenario runs only when SPI_ARB_TIMEOUT_EN is defined.
module tb_spi_txn_arbiter;

    localparam int NUM_REQ     = 4;
    localparam int SETTLE_CYC  = 2;
    localparam int TIMEOUT_CYC = 64;
    localparam int XFER_CYC    = 10;

    logic                   P_CLK   = 1'b0;
    logic                   reset_n = 1'b0;
    logic [NUM_REQ-1:0]     i_REQ      = '0;
    logic [NUM_REQ-1:0]     i_LOCK     = '0;
    logic [NUM_REQ*8-1:0]   i_REQ_DATA = '0;
    logic [NUM_REQ*2-1:0]   i_REQ_SS   = '0;
    logic [NUM_REQ*2-1:0]   i_REQ_MODE = '0;
    logic [NUM_REQ-1:0]     o_GNT, o_DONE;
    logic                   o_ERR, o_TX_START, o_MODE_SET;
    logic [7:0]             o_RX_BYTE, o_TX_DATA;
    logic [1:0]             o_SS, o_SPI_MODE;

    logic       m_spic, m_busy, m_cpol;
    logic       m_hang = 1'b0;
    logic [7:0] m_rx, m_tx;
    int         m_cnt;

    always #5 P_CLK = ~P_CLK;

    spi_txn_arbiter #(
        .NUM_REQ     (NUM_REQ),
        .SETTLE_CYC  (SETTLE_CYC),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .P_CLK      (P_CLK),
        .reset_n    (reset_n),
        .i_REQ      (i_REQ),
        .i_LOCK     (i_LOCK),
        .i_REQ_DATA (i_REQ_DATA),
        .i_REQ_SS   (i_REQ_SS),
        .i_REQ_MODE (i_REQ_MODE),
        .o_GNT      (o_GNT),
        .o_DONE     (o_DONE),
        .o_ERR      (o_ERR),
        .o_RX_BYTE  (o_RX_BYTE),
        .o_TX_DATA  (o_TX_DATA),
        .o_TX_START (o_TX_START),
        .o_SS       (o_SS),
        .o_SPI_MODE (o_SPI_MODE),
        .o_MODE_SET (o_MODE_SET),
        .i_SPIC     (m_spic),
        .i_RX_DATA  (m_rx)
    );

    // Master model: o_SPIC drops 2 cycles after start, returns the TX byte.
    always @(posedge P_CLK or negedge reset_n) begin
        if (!reset_n) begin
            m_spic <= 1'b1;
            m_busy <= 1'b0;
            m_cpol <= 1'b0;
            m_rx   <= 8'h00;
            m_tx   <= 8'h00;
            m_cnt  <= 0;
        end else begin
            if (o_MODE_SET) m_cpol <= o_SPI_MODE[1];
            if (!m_busy) begin
                if (o_TX_START) begin
                    m_busy <= 1'b1;
                    m_cnt  <= 0;
                    m_tx   <= o_TX_DATA;
                end
            end else begin
                if (!(m_hang && m_cnt >= 2)) m_cnt <= m_cnt + 1;
                if (m_cnt == 1) m_spic <= 1'b0;
                if (m_cnt == XFER_CYC && !m_hang) begin
                    m_spic <= 1'b1;
                    m_busy <= 1'b0;
                    m_rx   <= m_tx;
                end
            end
        end
    end

    typedef struct packed {
        logic [NUM_REQ-1:0] done;
        logic [7:0]         tx;
        logic [7:0]         rx;
        logic [1:0]         ss;
        logic               err;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0, n_errors = 0;
    int   cyc = 0, n_start = 0, ms_cnt = 0, ms_cyc = 0, st_cyc = 0, done_cyc = 0;
    logic st_cpol = 1'b0;
    int   rem[NUM_REQ];
    int   n0, m0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic push(input int k, input logic [7:0] tx, input logic [1:0] ss, input logic err);
        exp_t e;
        e.done    = '0;
        e.done[k] = 1'b1;
        e.tx      = tx;
        e.rx      = err ? 8'h00 : tx;
        e.ss      = ss;
        e.err     = err;
        sb.push_back(e);
    endtask

    task automatic set_req(input int k, input logic [7:0] d, input logic [1:0] ss,
                           input logic [1:0] mode, input int n, input logic lock);
        i_REQ_DATA[8*k +: 8] = d;
        i_REQ_SS[2*k +: 2]   = ss;
        i_REQ_MODE[2*k +: 2] = mode;
        i_LOCK[k]            = lock;
        rem[k]               = n;
        i_REQ[k]             = 1'b1;
    endtask

    // One cycle: sample at negedge, score o_DONE, play the requester side.
    task automatic step();
        exp_t e;
        @(negedge P_CLK);
        cyc++;
        if (o_MODE_SET) begin ms_cnt++; ms_cyc = cyc; end
        if (o_TX_START) begin n_start++; st_cyc = cyc; st_cpol = m_cpol; end
        if (o_DONE != '0) begin
            done_cyc = cyc;
            if (sb.size() == 0) begin
                check("unexpected_done", 32'(o_DONE), 32'(0));
            end else begin
                e = sb.pop_front();
                check("done_vec", 32'(o_DONE),    32'(e.done));
                check("rx_byte",  32'(o_RX_BYTE), 32'(e.rx));
                check("tx_data",  32'(o_TX_DATA), 32'(e.tx));
                check("ss",       32'(o_SS),      32'(e.ss));
                check("err",      32'(o_ERR),     32'(e.err));
            end
            for (int k = 0; k < NUM_REQ; k++) begin
                if (o_DONE[k]) begin
                    if (rem[k] > 0) rem[k]--;
                    if (rem[k] == 0) begin
                        i_REQ[k]  = 1'b0;
                        i_LOCK[k] = 1'b0;
                    end else begin
                        i_REQ_DATA[8*k +: 8] = i_REQ_DATA[8*k +: 8] + 8'd1;
                    end
                end
            end
        end
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (sb.size() == 0 && i_REQ == '0 && o_GNT == '0) break;
            step();
        end
        check("drain_sb_left", 32'(sb.size()), 32'(0));
    endtask

    initial begin
        repeat (3) @(negedge P_CLK);
        check("reset_outs", 32'({o_GNT, o_DONE, o_ERR, o_RX_BYTE, o_TX_DATA, o_TX_START,
                                 o_SS, o_SPI_MODE, o_MODE_SET}), 32'(0));
        reset_n = 1'b1;
        step();
        step();

        // Single request, grant and start latency
        n0 = n_start;
        push(1, 8'hA5, 2'b10, 1'b0);
        set_req(1, 8'hA5, 2'b10, 2'b00, 1, 1'b0);
        step();
        check("gnt_latency", 32'(o_GNT), 32'(4'b0010));
        check("start_not_yet", 32'(o_TX_START), 32'(0));
        step();
        check("start_pulse", 32'(o_TX_START), 32'(1));
        check("start_ss", 32'(o_SS), 32'(2'b10));
        check("start_data", 32'(o_TX_DATA), 32'(8'hA5));
        drain(100);
        check("one_start", 32'(n_start - n0), 32'(1));

        // Mode change: mode 0 then mode 3
        m0 = ms_cnt;
        push(0, 8'h11, 2'b01, 1'b0);
        set_req(0, 8'h11, 2'b01, 2'b00, 1, 1'b0);
        drain(100);
        check("no_mode_set_same_mode", 32'(ms_cnt - m0), 32'(0));
        m0 = ms_cnt;
        push(2, 8'h3C, 2'b11, 1'b0);
        set_req(2, 8'h3C, 2'b11, 2'b11, 1, 1'b0);
        drain(100);
        check("mode_set_once", 32'(ms_cnt - m0), 32'(1));
        check("settle_gap", 32'(st_cyc - ms_cyc), 32'(SETTLE_CYC + 1));
        check("sclk_idle_high", 32'(st_cpol), 32'(1));

        // Reset in WAIT_DONE, then pending requests from pointer 0
        set_req(3, 8'h77, 2'b00, 2'b00, 1, 1'b0);
        for (int i = 0; i < 100 && m_spic; i++) step();
        step();
        step();
        check("reached_wait_done", 32'(m_spic), 32'(0));
        reset_n = 1'b0;
        #1;
        check("async_reset_outs", 32'({o_GNT, o_DONE, o_ERR, o_RX_BYTE, o_TX_DATA, o_TX_START,
                                       o_SS, o_SPI_MODE, o_MODE_SET}), 32'(0));
        set_req(1, 8'h5A, 2'b01, 2'b00, 1, 1'b0);
        rem[3] = 1;
        push(1, 8'h5A, 2'b01, 1'b0);
        push(3, 8'h77, 2'b00, 1'b0);
        step();
        step();
        reset_n = 1'b1;
        drain(200);

        // All four requesting: two full round-robin rounds
        for (int k = 0; k < NUM_REQ; k++)
            set_req(k, 8'(16 * (k + 1)), 2'(k), 2'b00, 2, 1'b0);
        for (int r = 0; r < 2; r++)
            for (int k = 0; k < NUM_REQ; k++)
                push(k, 8'(16 * (k + 1) + r), 2'(k), 1'b0);
        drain(600);

        // Locked burst of 20 with req1 waiting: 16, then req1, then the last 4
        set_req(0, 8'h40, 2'b00, 2'b00, 20, 1'b1);
        set_req(1, 8'h99, 2'b01, 2'b00, 1, 1'b0);
        for (int j = 0; j < 16; j++) push(0, 8'(8'h40 + j), 2'b00, 1'b0);
        push(1, 8'h99, 2'b01, 1'b0);
        for (int j = 16; j < 20; j++) push(0, 8'(8'h40 + j), 2'b00, 1'b0);
        drain(1000);

`ifdef SPI_ARB_TIMEOUT_EN
        // Stalled master: watchdog completes with error, next grant re-issues mode
        m_hang = 1'b1;
        push(2, 8'hC3, 2'b10, 1'b1);
        set_req(2, 8'hC3, 2'b10, 2'b00, 1, 1'b0);
        drain(300);
        check("timeout_latency", 32'(done_cyc - st_cyc), 32'(TIMEOUT_CYC));
        m_hang = 1'b0;
        for (int i = 0; i < 50 && !m_spic; i++) step();
        m0 = ms_cnt;
        push(2, 8'h24, 2'b10, 1'b0);
        set_req(2, 8'h24, 2'b10, 2'b00, 1, 1'b0);
        drain(200);
        check("mode_reissue_after_timeout", 32'(ms_cnt - m0), 32'(1));
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
